trigger_engine: RTL

- Parametrised successor to the per-channel equality trigger.
- Adds rising/falling/either edge crossing with hysteresis, AND/OR channel combining, an enable/holdoff state machine and a trigger counter.
- Sits between the ADC sample deserialiser and the capture buffer.
- Forwards sample data delayed to align exactly with the trig pulse.

---
 rtl/trigger_engine.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/trigger_engine.sv
// -----------------------------------------------------------------------------
// trigger_engine : multi-channel level/edge trigger with hysteresis, holdoff and
//                  a saturating trigger counter; data is forwarded aligned to trig.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module trigger_engine #(
  parameter int CHANNEL_NUM = 4,
  parameter int BIT_NUM     = 16,
  parameter int HOLDOFF_W   = 16,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           trig_en,
  input  logic [1:0]                     trig_mode,
  input  logic                           trig_combine,
  input  logic [CHANNEL_NUM-1:0]         trig_mask,
  input  logic [BIT_NUM-1:0]             trig_level,
  input  logic [BIT_NUM-1:0]             trig_hyst,
  input  logic [HOLDOFF_W-1:0]           trig_holdoff,
  input  logic [BIT_NUM*CHANNEL_NUM-1:0] idata,
  input  logic                           idata_valid,
  output logic [BIT_NUM*CHANNEL_NUM-1:0] odata,
  output logic                           odata_valid,
  output logic                           trig,
  output logic [CHANNEL_NUM-1:0]         trig_ch,
  output logic                           busy,
  output logic [CNT_W-1:0]               trig_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [HOLDOFF_W-1:0]             r_hold;
  logic [CHANNEL_NUM-1:0]           r_arm_r;
  logic [CHANNEL_NUM-1:0]           r_arm_f;
  logic [CHANNEL_NUM-1:0]           w_arm_r_nxt;
  logic [CHANNEL_NUM-1:0]           w_arm_f_nxt;
  logic [CHANNEL_NUM-1:0]           w_hit;
  logic [BIT_NUM*CHANNEL_NUM-1:0]   r_s1_data;
  logic                             r_s1_valid;
  logic [CHANNEL_NUM-1:0]           r_s1_hit;
  logic [BIT_NUM:0]                 w_lo_ext;
  logic [BIT_NUM:0]                 w_hi_ext;
  logic [BIT_NUM-1:0]               w_lo;
  logic [BIT_NUM-1:0]               w_hi;
  logic [CHANNEL_NUM-1:0]           w_masked;
  logic                             w_any;
  logic                             w_all;
  logic                             w_comb;
  logic                             w_fire;

  // One extra bit exposes borrow/carry so the band saturates at the range ends.
  assign w_lo_ext = {1'b0, trig_level} - {1'b0, trig_hyst};
  assign w_hi_ext = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign w_lo     = w_lo_ext[BIT_NUM] ? '0 : w_lo_ext[BIT_NUM-1:0];
  assign w_hi     = w_hi_ext[BIT_NUM] ? '1 : w_hi_ext[BIT_NUM-1:0];

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    logic [BIT_NUM-1:0] w_x;
    logic               w_rise_hit;
    logic               w_fall_hit;

    assign w_x        = idata[i*BIT_NUM +: BIT_NUM];
    assign w_rise_hit = r_arm_r[i] && (w_x >= trig_level);
    assign w_fall_hit = r_arm_f[i] && (w_x <= trig_level);

    assign w_hit[i] = (trig_mode == 2'd0) ? (w_x == trig_level) :
                      (trig_mode == 2'd1) ? w_rise_hit :
                      (trig_mode == 2'd2) ? w_fall_hit :
                                            (w_rise_hit | w_fall_hit);

    // Re-arming takes priority so a sample inside a zero-width band hits and re-arms.
    assign w_arm_r_nxt[i] = (w_x <= w_lo) ? 1'b1 : (w_rise_hit ? 1'b0 : r_arm_r[i]);
    assign w_arm_f_nxt[i] = (w_x >= w_hi) ? 1'b1 : (w_fall_hit ? 1'b0 : r_arm_f[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_arm_r <= '0;
      r_arm_f <= '0;
    end else if (!trig_en || (r_state == ST_IDLE)) begin
      r_arm_r <= '0;
      r_arm_f <= '0;
    end else if (idata_valid) begin
      r_arm_r <= w_arm_r_nxt;
      r_arm_f <= w_arm_f_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hit   <= '0;
    end else begin
      r_s1_data  <= idata;
      r_s1_valid <= idata_valid;
      r_s1_hit   <= idata_valid ? w_hit : '0;
    end
  end

  assign w_masked = r_s1_hit & trig_mask;
  assign w_any    = |w_masked;
  assign w_all    = (trig_mask != '0) && (w_masked == trig_mask);
  assign w_comb   = trig_combine ? w_all : w_any;
  assign w_fire   = (r_state == ST_ARMED) && r_s1_valid && w_comb;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!trig_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_ARMED;
        ST_ARMED:   if (w_fire && (trig_holdoff != '0)) w_state_nxt = ST_HOLDOFF;
        ST_HOLDOFF: if (r_s1_valid && (r_hold <= HOLDOFF_W'(1))) w_state_nxt = ST_ARMED;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Holdoff counts valid samples only, so gaps in the strobe stretch it in time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold <= '0;
    end else if (!trig_en) begin
      r_hold <= '0;
    end else if (w_fire) begin
      r_hold <= trig_holdoff;
    end else if ((r_state == ST_HOLDOFF) && r_s1_valid && (r_hold != '0)) begin
      r_hold <= r_hold - HOLDOFF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      odata       <= '0;
      odata_valid <= 1'b0;
      trig        <= 1'b0;
      trig_ch     <= '0;
      trig_cnt    <= '0;
    end else begin
      odata       <= r_s1_data;
      odata_valid <= r_s1_valid;
      trig        <= w_fire;
      trig_ch     <= w_fire ? w_masked : '0;
      if (w_fire && (trig_cnt != '1)) begin
        trig_cnt <= trig_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (r_state == ST_HOLDOFF);

endmodule

`default_nettype wire
